// File: rtl/front_panel_input.sv
// Front panel input controller: buttons -> cursor position/action, latched toggles, momentary command pulses.
// Latency: 3 clk from button pin to registered outputs; no backpressure, every output is a free-running register.
module front_panel_input #(
    parameter int HOLD_FRAMES   = 20,
    parameter int REPEAT_FRAMES = 6,
    parameter int ACTION_FRAMES = 8,
    parameter int ROW0_MAX_X    = 15,
    parameter int ROW1_MAX_X    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire_a,
    input  logic        btn_fire_b,
    output logic [3:0]  cursor_index_x,
    output logic [4:0]  cursor_index_y,
    output logic [1:0]  cursor_action,
    output logic [15:0] sw_data,
    output logic        power_on,
    output logic [7:0]  cmd_up,
    output logic [7:0]  cmd_down
);

    localparam int CW = 8;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_FRAMES - 1);
    localparam logic [CW-1:0] ACT_LOAD    = CW'(ACTION_FRAMES);
    localparam logic [3:0]    ROW0_MAX    = 4'(ROW0_MAX_X);
    localparam logic [3:0]    ROW1_MAX    = 4'(ROW1_MAX_X);

    localparam logic [1:0] D_IDLE   = 2'd0;
    localparam logic [1:0] D_HOLD   = 2'd1;
    localparam logic [1:0] D_REPEAT = 2'd2;
    localparam logic [0:0] A_IDLE   = 1'b0;
    localparam logic [0:0] A_ACTIVE = 1'b1;

    // bit order: {vsync, fire_b, fire_a, right, left, down, up}
    logic [6:0] w_in;
    logic [6:0] r_sync1, r_sync2, r_prev;
    logic [6:0] w_rise;
    logic [3:0] w_dir, w_dir_rise;
    logic [1:0] w_fire_rise;
    logic       w_frame_tick;
    logic       w_dir_single;

    logic [1:0]    r_dstate, w_dstate_nx;
    logic [CW-1:0] r_dcnt, w_dcnt_nx;
    logic [3:0]    r_held;
    logic          w_step;
    logic [3:0]    w_row_max;
    logic [3:0]    w_nx;
    logic [4:0]    w_ny;

    logic [0:0]    r_astate;
    logic [CW-1:0] r_acnt;
    logic          w_fire_one;
    logic [4:0]    w_idx;
    logic [7:0]    w_cmd_mask;

    assign w_in         = {vsync, btn_fire_b, btn_fire_a, btn_right, btn_left, btn_down, btn_up};
    assign w_rise       = r_sync2 & ~r_prev;
    assign w_dir        = r_sync2[3:0];
    assign w_dir_rise   = w_rise[3:0];
    assign w_fire_rise  = w_rise[5:4];
    assign w_frame_tick = w_rise[6];
    assign w_dir_single = (w_dir != 4'd0) && ((w_dir & (w_dir - 4'd1)) == 4'd0);
    assign w_fire_one   = (w_fire_rise == 2'b01) || (w_fire_rise == 2'b10);
    assign w_idx        = {1'b0, cursor_index_x} + cursor_index_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Direction auto-repeat; an active throw parks it in IDLE so held buttons need a fresh edge.
    always_comb begin
        w_step      = 1'b0;
        w_dstate_nx = r_dstate;
        w_dcnt_nx   = r_dcnt;
        if (r_astate == A_ACTIVE) begin
            w_dstate_nx = D_IDLE;
            w_dcnt_nx   = '0;
        end else begin
            case (r_dstate)
                D_IDLE: begin
                    if (w_dir_rise != 4'd0 && w_dir_single) begin
                        w_step      = 1'b1;
                        w_dstate_nx = D_HOLD;
                        w_dcnt_nx   = '0;
                    end
                end
                D_HOLD: begin
                    if (w_dir != r_held) begin
                        w_dstate_nx = D_IDLE;
                    end else if (w_frame_tick) begin
                        if (r_dcnt == HOLD_LAST) begin
                            w_step      = 1'b1;
                            w_dstate_nx = D_REPEAT;
                            w_dcnt_nx   = '0;
                        end else begin
                            w_dcnt_nx = r_dcnt + 8'd1;
                        end
                    end
                end
                D_REPEAT: begin
                    if (w_dir != r_held) begin
                        w_dstate_nx = D_IDLE;
                    end else if (w_frame_tick) begin
                        if (r_dcnt == REPEAT_LAST) begin
                            w_step    = 1'b1;
                            w_dcnt_nx = '0;
                        end else begin
                            w_dcnt_nx = r_dcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_dstate_nx = D_IDLE;
                    w_dcnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_row_max = (cursor_index_y == 5'd0) ? ROW0_MAX : ROW1_MAX;
        w_nx      = cursor_index_x;
        w_ny      = cursor_index_y;
        if (w_dir[0] || w_dir[1]) begin
            w_ny = (cursor_index_y == 5'd0) ? 5'd16 : 5'd0;
            if (w_ny != 5'd0 && cursor_index_x > ROW1_MAX) begin
                w_nx = ROW1_MAX;
            end
        end else if (w_dir[2]) begin
            w_nx = (cursor_index_x == 4'd0) ? w_row_max : cursor_index_x - 4'd1;
        end else if (w_dir[3]) begin
            w_nx = (cursor_index_x >= w_row_max) ? 4'd0 : cursor_index_x + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dstate       <= D_IDLE;
            r_dcnt         <= '0;
            r_held         <= '0;
            cursor_index_x <= '0;
            cursor_index_y <= '0;
        end else begin
            r_dstate <= w_dstate_nx;
            r_dcnt   <= w_dcnt_nx;
            if (w_step) begin
                r_held         <= w_dir;
                cursor_index_x <= w_nx;
                cursor_index_y <= w_ny;
            end
        end
    end

    always_comb begin
        w_cmd_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_cmd_mask[i] = (w_idx == 5'(17 + i));
        end
    end

    // A throw updates the target and the displayed action in the same clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_astate      <= A_IDLE;
            r_acnt        <= '0;
            cursor_action <= 2'd0;
            sw_data       <= '0;
            power_on      <= 1'b0;
            cmd_up        <= '0;
            cmd_down      <= '0;
        end else begin
            cmd_up   <= '0;
            cmd_down <= '0;
            case (r_astate)
                A_IDLE: begin
                    if (w_fire_one) begin
                        cursor_action <= w_fire_rise[0] ? 2'd1 : 2'd2;
                        r_acnt        <= ACT_LOAD;
                        r_astate      <= A_ACTIVE;
                        if (w_idx <= 5'd15) begin
                            sw_data[w_idx[3:0]] <= w_fire_rise[0];
                        end else if (w_idx == 5'd16) begin
                            power_on <= w_fire_rise[0];
                        end else if (w_fire_rise[0]) begin
                            cmd_up <= w_cmd_mask;
                        end else begin
                            cmd_down <= w_cmd_mask;
                        end
                    end
                end
                default: begin
                    if (w_frame_tick) begin
                        r_acnt <= r_acnt - 8'd1;
                        if (r_acnt <= 8'd1) begin
                            cursor_action <= 2'd0;
                            r_astate      <= A_IDLE;
                            r_acnt        <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_front_panel_input.sv
// Bench for front_panel_input: directed scenarios plus random operation sequences against an operation-level model.
module tb_front_panel_input;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        btn_up, btn_down, btn_left, btn_right, btn_fire_a, btn_fire_b;
    logic [3:0]  cursor_index_x;
    logic [4:0]  cursor_index_y;
    logic [1:0]  cursor_action;
    logic [15:0] sw_data;
    logic        power_on;
    logic [7:0]  cmd_up, cmd_down;

    int n_cmp = 0;
    int n_bad = 0;

    // operation-level model of the panel
    int          mx, my, m_act, m_rem;
    logic [15:0] m_sw;
    logic        m_pw;

    logic [27:0] obs;
    assign obs = {cursor_index_x, cursor_index_y, cursor_action, sw_data, power_on};

    always #5 clk = ~clk;

    front_panel_input dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire_a(btn_fire_a), .btn_fire_b(btn_fire_b),
        .cursor_index_x(cursor_index_x), .cursor_index_y(cursor_index_y),
        .cursor_action(cursor_action), .sw_data(sw_data), .power_on(power_on),
        .cmd_up(cmd_up), .cmd_down(cmd_down)
    );

    function automatic logic [27:0] state_exp();
        return {4'(mx), 5'(my), 2'(m_act), m_sw, m_pw};
    endfunction

    function automatic void model_reset();
        mx = 0; my = 0; m_act = 0; m_rem = 0; m_sw = '0; m_pw = 1'b0;
    endfunction

    // d: 0 up, 1 down, 2 left, 3 right
    function automatic void model_step(int d);
        int rmax;
        rmax = (my == 0) ? 15 : 8;
        if (d <= 1) begin
            my = (my == 0) ? 16 : 0;
            if (my == 16 && mx > 8) mx = 8;
        end else if (d == 2) begin
            mx = (mx == 0) ? rmax : mx - 1;
        end else begin
            mx = (mx >= rmax) ? 0 : mx + 1;
        end
    endfunction

    task automatic set_dir(int d, logic v);
        case (d)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic tap_dir(int d);
        @(negedge clk); set_dir(d, 1'b1);
        repeat (6) @(negedge clk);
        set_dir(d, 1'b0);
        repeat (6) @(negedge clk);
        if (m_act == 0) model_step(d);
    endtask

    task automatic frames(int n);
        repeat (n) begin
            @(negedge clk); vsync = 1'b1;
            repeat (4) @(negedge clk);
            vsync = 1'b0;
            repeat (4) @(negedge clk);
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_act = 0;
            end
        end
    endtask

    // Drives one fire press; returns observed pulses and the pulses the model expects.
    task automatic fire_tap(input logic a, input logic b,
                            output logic [7:0] su, output logic [7:0] sd, output int pc,
                            output logic [7:0] eu, output logic [7:0] ed);
        int idx;
        su = '0; sd = '0; pc = 0; eu = '0; ed = '0;
        if (m_act == 0 && (a ^ b)) begin
            idx = mx + my;
            if (idx <= 15) m_sw[idx] = a;
            else if (idx == 16) m_pw = a;
            else if (a) eu = 8'(1 << (idx - 17));
            else ed = 8'(1 << (idx - 17));
            m_act = a ? 1 : 2;
            m_rem = 8;
        end
        @(negedge clk); btn_fire_a = a; btn_fire_b = b;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 5) begin btn_fire_a = 1'b0; btn_fire_b = 1'b0; end
            if ((cmd_up | cmd_down) != 8'd0) pc++;
            su |= cmd_up;
            sd |= cmd_down;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vsync = 1'b0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire_a = 0; btn_fire_b = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({obs, cmd_up, cmd_down} !== 44'd0) begin
            n_bad++; $display("FAIL reset_hold: got %h want 0", {obs, cmd_up, cmd_down});
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({obs, cmd_up, cmd_down} !== 44'd0) begin
            n_bad++; $display("FAIL reset_release: got %h want 0", {obs, cmd_up, cmd_down});
        end
    endtask

    task automatic test_step();
        for (int i = 0; i < 3; i++) begin
            tap_dir(3);
            n_cmp++;
            if (obs !== state_exp()) begin
                n_bad++; $display("FAIL step_right%0d: got %h want %h", i, obs, state_exp());
            end
        end
        n_cmp++;
        if ({cursor_index_x, cursor_index_y, cursor_action, sw_data, power_on, cmd_up, cmd_down} !== {4'd3, 40'd0}) begin
            n_bad++; $display("FAIL step_x3: got x=%0d y=%0d want x=3 y=0", cursor_index_x, cursor_index_y);
        end
    endtask

    task automatic test_hold();
        int seg[5];
        seg = '{19, 1, 6, 6, 6};
        for (int i = 0; i < 3; i++) tap_dir(2);
        @(negedge clk); btn_right = 1'b1;
        repeat (6) @(negedge clk);
        model_step(3);
        for (int s = 0; s < 5; s++) begin
            frames(seg[s]);
            if (s > 0) model_step(3);
            n_cmp++;
            if (obs !== state_exp()) begin
                n_bad++; $display("FAIL hold_seg%0d: got x=%0d want x=%0d", s, cursor_index_x, mx);
            end
        end
        frames(2);
        btn_right = 1'b0;
        repeat (6) @(negedge clk);
        frames(5);
        n_cmp++;
        if (cursor_index_x !== 4'd5) begin
            n_bad++; $display("FAIL hold_release: got x=%0d want x=5", cursor_index_x);
        end
    endtask

    task automatic test_row();
        while (mx != 12) tap_dir(3);
        tap_dir(0);
        n_cmp++;
        if ({cursor_index_x, cursor_index_y} !== {4'd8, 5'd16}) begin
            n_bad++; $display("FAIL row_clamp: got x=%0d y=%0d want x=8 y=16", cursor_index_x, cursor_index_y);
        end
        tap_dir(3);
        n_cmp++;
        if ({cursor_index_x, cursor_index_y} !== {4'd0, 5'd16}) begin
            n_bad++; $display("FAIL row1_wrap_right: got x=%0d y=%0d want x=0 y=16", cursor_index_x, cursor_index_y);
        end
        tap_dir(2);
        n_cmp++;
        if ({cursor_index_x, cursor_index_y} !== {4'd8, 5'd16}) begin
            n_bad++; $display("FAIL row1_wrap_left: got x=%0d y=%0d want x=8 y=16", cursor_index_x, cursor_index_y);
        end
    endtask

    task automatic test_fire_toggle();
        logic [7:0] su, sd, eu, ed;
        int pc;
        tap_dir(1);
        while (mx != 5) tap_dir(2);
        fire_tap(1'b1, 1'b0, su, sd, pc, eu, ed);
        n_cmp++;
        if ({sw_data, cursor_action, pc} !== {16'h0020, 2'd1, 32'd0}) begin
            n_bad++; $display("FAIL fire_a_sw: got sw=%h act=%0d pulses=%0d want sw=0020 act=1 pulses=0", sw_data, cursor_action, pc);
        end
        for (int f = 1; f <= 8; f++) begin
            frames(1);
            n_cmp++;
            if (cursor_action !== ((f < 8) ? 2'd1 : 2'd0)) begin
                n_bad++; $display("FAIL action_len f%0d: got %0d want %0d", f, cursor_action, (f < 8) ? 1 : 0);
            end
        end
        fire_tap(1'b0, 1'b1, su, sd, pc, eu, ed);
        n_cmp++;
        if ({sw_data, cursor_action} !== {16'h0000, 2'd2}) begin
            n_bad++; $display("FAIL fire_b_sw: got sw=%h act=%0d want sw=0000 act=2", sw_data, cursor_action);
        end
        frames(8);
    endtask

    task automatic test_cmd();
        logic [7:0] su, sd, eu, ed;
        int pc;
        tap_dir(0);
        while (mx != 2) tap_dir(2);
        fire_tap(1'b0, 1'b1, su, sd, pc, eu, ed);
        n_cmp++;
        if ({su, sd, pc, sw_data} !== {8'h00, 8'h02, 32'd1, m_sw}) begin
            n_bad++; $display("FAIL cmd_down18: got up=%h down=%h pulses=%0d sw=%h want up=00 down=02 pulses=1 sw=%h", su, sd, pc, sw_data, m_sw);
        end
        tap_dir(3);
        n_cmp++;
        if (cursor_index_x !== 4'd2) begin
            n_bad++; $display("FAIL move_blocked: got x=%0d want x=2", cursor_index_x);
        end
        frames(8);
        n_cmp++;
        if (obs !== state_exp()) begin
            n_bad++; $display("FAIL cmd_after: got %h want %h", obs, state_exp());
        end
    endtask

    task automatic test_both_fire();
        logic [7:0] su, sd, eu, ed;
        int pc;
        fire_tap(1'b1, 1'b1, su, sd, pc, eu, ed);
        n_cmp++;
        if ({cursor_action, pc, obs} !== {2'd0, 32'd0, state_exp()}) begin
            n_bad++; $display("FAIL both_fire: got act=%0d pulses=%0d want act=0 pulses=0", cursor_action, pc);
        end
    endtask

    task automatic test_random();
        logic [7:0] su, sd, eu, ed;
        int pc, op;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 6);
            if (op <= 3) begin
                tap_dir(op);
            end else if (op <= 5) begin
                fire_tap(op == 4, op == 5, su, sd, pc, eu, ed);
                n_cmp++;
                if ({su, sd, pc} !== {eu, ed, ((eu | ed) != 0) ? 32'd1 : 32'd0}) begin
                    n_bad++; $display("FAIL rand_pulse%0d: got up=%h down=%h pulses=%0d want up=%h down=%h", n, su, sd, pc, eu, ed);
                end
            end else begin
                frames($urandom_range(1, 3));
            end
            n_cmp++;
            if (obs !== state_exp()) begin
                n_bad++; $display("FAIL rand_state%0d op%0d: got %h want %h", n, op, obs, state_exp());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] su, sd, eu, ed;
        int pc;
        frames(8);
        if (my != 0) tap_dir(0);
        while (mx != 0) tap_dir(2);
        fire_tap(1'b1, 1'b0, su, sd, pc, eu, ed);
        frames(8);
        tap_dir(1);
        fire_tap(1'b1, 1'b0, su, sd, pc, eu, ed);
        frames(2);
        n_cmp++;
        if ({cursor_action, sw_data[0], power_on} !== {2'd1, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL pre_reset: got act=%0d sw0=%b pwr=%b want act=1 sw0=1 pwr=1", cursor_action, sw_data[0], power_on);
        end
        @(negedge clk); reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs, cmd_up, cmd_down} !== 44'd0) begin
            n_bad++; $display("FAIL reset_mid: got %h want 0", {obs, cmd_up, cmd_down});
        end
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs !== state_exp()) begin
            n_bad++; $display("FAIL reset_mid_after: got %h want %h", obs, state_exp());
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_hold();
        test_row();
        test_fire_toggle();
        test_cmd();
        test_both_fire();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
